// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient}; signed results take the C truncating convention.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, DIVON, END} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             sgn_mode_q, sign1_q, sign2_q;

  logic             neg1, neg2, last;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] rem_nx, quo_nx, rem_fix, quo_fix;

  assign busy_o = (state == BYZERO) || (state == DIVON);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    neg1 = signed_div_i & opdata1_i[WIDTH-1];
    neg2 = signed_div_i & opdata2_i[WIDTH-1];
    mag1 = neg1 ? -opdata1_i : opdata1_i;
    mag2 = neg2 ? -opdata2_i : opdata2_i;
  end

  // The remainder stays below the divisor, so only WIDTH bits are stored;
  // the WIDTH+1-bit partial remainder exists only between shift and compare.
  always_comb begin
    part   = {rem_q, quo_q[WIDTH-1]};
    quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    rem_nx = part[WIDTH-1:0];
    if (part >= {1'b0, dvs_q}) begin
      rem_nx    = WIDTH'(part - {1'b0, dvs_q});
      quo_nx[0] = 1'b1;
    end
    quo_fix = (sgn_mode_q & (sign1_q ^ sign2_q)) ? -quo_nx : quo_nx;
    rem_fix = (sgn_mode_q & sign1_q) ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_nx = state;
    if (annul_i) begin
      state_nx = FREE;
    end else begin
      case (state)
        FREE:   if (start_i) state_nx = (opdata2_i == '0) ? BYZERO : DIVON;
        BYZERO: state_nx = END;
        DIVON:  if (last) state_nx = END;
        END:    if (!start_i) state_nx = FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FREE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sgn_mode_q <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else if (annul_i) begin
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i) begin
            sgn_mode_q <= signed_div_i;
            sign1_q    <= opdata1_i[WIDTH-1];
            sign2_q    <= opdata2_i[WIDTH-1];
            rem_q      <= '0;
            quo_q      <= mag1;
            dvs_q      <= mag2;
            cnt        <= '0;
          end
        end
        BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        DIVON: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq at WIDTH=32 and WIDTH=8.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        sd32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        ready32, busy32;

  logic        sd8 = 1'b0, start8 = 1'b0, annul8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        ready8, busy8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst_n(rst_n), .signed_div_i(sd32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(ready32), .busy_o(busy32)
  );

  div_seq #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .signed_div_i(sd8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(ready8), .busy_o(busy8)
  );

  // The negedge at which start is raised is cycle 0.
  task automatic start_op32(input logic sd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sd32 = sd; a32 = a; b32 = b; start32 = 1'b1;
  endtask

  task automatic wait_ready32(input int exp_cyc, input logic [63:0] exp_res, input string name);
    int  k;
    int  bad;
    bit  got;
    k = 0; bad = 0; got = 1'b0;
    while (!got && k < exp_cyc + 8) begin
      @(negedge clk);
      k++;
      if (busy32 !== (k < exp_cyc)) bad++;
      if (ready32 === 1'b1) got = 1'b1;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s busy: wrong busy_o in %0d cycles, required high only in cycles 1..%0d", name, bad, exp_cyc - 1);
    end
    checks++;
    if (!got || k !== exp_cyc) begin
      errors++;
      $display("FAIL %s latency: ready_o at cycle %0d (seen=%0d), required %0d", name, k, got, exp_cyc);
    end
    checks++;
    if (res32 !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h, required %h", name, res32, exp_res);
    end
  endtask

  // Holds start one more cycle, then drops it; returns in the first FREE cycle.
  task automatic release32(input logic [63:0] exp_res, input string name);
    @(negedge clk);
    checks++;
    if (ready32 !== 1'b1 || res32 !== exp_res) begin
      errors++;
      $display("FAIL %s hold: ready=%b result=%h, required ready=1 result=%h", name, ready32, res32, exp_res);
    end
    start32 = 1'b0;
    @(negedge clk);
    checks++;
    if (ready32 !== 1'b0 || res32 !== 64'h0 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL %s drop: ready=%b busy=%b result=%h, required 0/0/0", name, ready32, busy32, res32);
    end
  endtask

  task automatic run32(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cyc, input logic [63:0] exp_res, input string name);
    start_op32(sd, a, b);
    wait_ready32(exp_cyc, exp_res, name);
    release32(exp_res, name);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (res32 !== 64'h0 || ready32 !== 1'b0 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL reset32: result=%h ready=%b busy=%b, required all 0", res32, ready32, busy32);
    end
    checks++;
    if (res8 !== 16'h0 || ready8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: result=%h ready=%b busy=%b, required all 0", res8, ready8, busy8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    run32(1'b0, 32'd100,       32'd7,    33, {32'h00000002, 32'h0000000E}, "u100_7");
    run32(1'b0, 32'hFFFFFFFF,  32'h10,   33, {32'h0000000F, 32'h0FFFFFFF}, "uffff_16");
    run32(1'b0, 32'd5,         32'd7,    33, {32'h00000005, 32'h00000000}, "u5_7");
    run32(1'b0, 32'hFFFFFFF9,  32'd2,    33, {32'h00000001, 32'h7FFFFFFC}, "u_big_2");
  endtask

  task automatic test_signed;
    run32(1'b1, 32'hFFFFFFF9,  32'h2,        33, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s-7_2");
    run32(1'b1, 32'h00000007,  32'hFFFFFFFE, 33, {32'h00000001, 32'hFFFFFFFD}, "s7_-2");
    run32(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 33, {32'hFFFFFFFE, 32'h0000000E}, "s-100_-7");
    run32(1'b1, 32'h80000000,  32'hFFFFFFFF, 33, {32'h00000000, 32'h80000000}, "smin_-1");
  endtask

  task automatic test_div_zero;
    run32(1'b0, 32'h1234, 32'h0, 2, 64'h0, "divzero_u");
    run32(1'b1, 32'hFFFFFFF0, 32'h0, 2, 64'h0, "divzero_s");
  endtask

  task automatic test_annul;
    int bad;
    bad = 0;
    start_op32(1'b0, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ready32 !== 1'b0) bad++;
    end
    // Cycle 10: abort while start stays high with the next request's operands.
    annul32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
    @(negedge clk);
    annul32 = 1'b0;
    checks++;
    if (bad !== 0 || ready32 !== 1'b0 || busy32 !== 1'b0 || res32 !== 64'h0) begin
      errors++;
      $display("FAIL annul: early ready count=%0d ready=%b busy=%b result=%h, required 0/0/0/0", bad, ready32, busy32, res32);
    end
    wait_ready32(33, {32'h0, 32'd10}, "restart50_5");
    release32({32'h0, 32'd10}, "restart50_5");
  endtask

  task automatic test_annul_start_free;
    @(negedge clk);
    sd32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1; annul32 = 1'b1;
    @(negedge clk);
    annul32 = 1'b0;
    checks++;
    if (busy32 !== 1'b0 || ready32 !== 1'b0) begin
      errors++;
      $display("FAIL annul_start_free: busy=%b ready=%b, required 0/0", busy32, ready32);
    end
    wait_ready32(33, {32'h2, 32'hE}, "after_annul_free");
    release32({32'h2, 32'hE}, "after_annul_free");
  endtask

  task automatic test_back_to_back;
    start_op32(1'b0, 32'd50, 32'd5);
    repeat (3) @(negedge clk);
    a32 = 32'hDEADBEEF; b32 = 32'd3; sd32 = 1'b1;
    wait_ready32(30, {32'h0, 32'd10}, "ignore_inputs");
    release32({32'h0, 32'd10}, "ignore_inputs");
    // First FREE cycle: raise the next request immediately.
    sd32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    wait_ready32(33, {32'h2, 32'hE}, "b2b");
    release32({32'h2, 32'hE}, "b2b");
  endtask

  task automatic test_reset_mid;
    start_op32(1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy32 !== 1'b0 || ready32 !== 1'b0 || res32 !== 64'h0) begin
      errors++;
      $display("FAIL reset_divon: busy=%b ready=%b result=%h, required 0/0/0", busy32, ready32, res32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset while holding a finished result.
    wait_ready32(33, {32'h2, 32'hE}, "resume");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready32 !== 1'b0 || res32 !== 64'h0) begin
      errors++;
      $display("FAIL reset_end: ready=%b result=%h, required 0/0", ready32, res32);
    end
    @(negedge clk);
    start32 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run8(input logic sd, input logic [7:0] a, input logic [7:0] b,
                      input int exp_cyc, input logic [15:0] exp_res, input string name);
    int k;
    bit got;
    k = 0; got = 1'b0;
    @(negedge clk);
    sd8 = sd; a8 = a; b8 = b; start8 = 1'b1;
    while (!got && k < exp_cyc + 8) begin
      @(negedge clk);
      k++;
      if (ready8 === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || k !== exp_cyc) begin
      errors++;
      $display("FAIL %s latency: ready_o at cycle %0d (seen=%0d), required %0d", name, k, got, exp_cyc);
    end
    checks++;
    if (res8 !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h, required %h", name, res8, exp_res);
    end
    start8 = 1'b0;
    @(negedge clk);
    checks++;
    if (ready8 !== 1'b0 || res8 !== 16'h0) begin
      errors++;
      $display("FAIL %s drop: ready=%b result=%h, required 0/0", name, ready8, res8);
    end
  endtask

  task automatic test_w8;
    run8(1'b0, 8'd200, 8'd3,  9, {8'h02, 8'h42}, "w8_u200_3");
    run8(1'b1, 8'h80,  8'hFF, 9, {8'h00, 8'h80}, "w8_smin_-1");
    run8(1'b1, 8'hF9,  8'h02, 9, {8'hFF, 8'hFD}, "w8_s-7_2");
    run8(1'b0, 8'h55,  8'h00, 2, 16'h0,          "w8_divzero");
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_annul;
    test_annul_start_free;
    test_back_to_back;
    test_reset_mid;
    test_w8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
